// File: rtl/parity_stream_gen_chk_if.sv
// Bundle for parity_stream_gen_chk: upstream beat channel with its packet sideband,
// plus the downstream result channel. The environment is master, the stage is slave.
interface parity_stream_gen_chk_if #(
    parameter int DATA_W = 8
);
    logic              mode_odd;
    logic              chk_en;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              s_par;

    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              m_beat_par;
    logic              m_pkt_par;
    logic              m_err;

    modport master (
        output mode_odd, chk_en, s_valid, s_data, s_last, s_par, m_ready,
        input  s_ready, m_valid, m_data, m_last, m_beat_par, m_pkt_par, m_err
    );

    modport slave (
        input  mode_odd, chk_en, s_valid, s_data, s_last, s_par, m_ready,
        output s_ready, m_valid, m_data, m_last, m_beat_par, m_pkt_par, m_err
    );
endinterface

// File: rtl/parity_stream_gen_chk.sv
// Single-register pipeline stage that generates per-beat and per-packet parity,
// optionally checks the packet parity, and counts errored packets (saturating).
module parity_stream_gen_chk #(
    parameter int DATA_W    = 8,
    parameter int MAX_BEATS = 16,
    parameter int CNT_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    parity_stream_gen_chk_if.slave bus,
    output logic [CNT_W-1:0]      err_cnt
);

    localparam int BW = $clog2(MAX_BEATS + 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t            state, state_nxt;
    logic [BW-1:0]     beat_cnt, beat_cnt_nxt;
    logic              acc, acc_nxt;
    logic              mode_q, mode_nxt;
    logic              chk_q, chk_nxt;

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic              last_q;
    logic              beat_par_q;
    logic              pkt_par_q;
    logic              err_q;

    logic              accept;
    logic              x;
    logic              first;
    logic              mode_cur;
    logic              chk_cur;
    logic              acc_cur;
    logic [BW-1:0]     count;
    logic              is_last;
    logic              forced;
    logic              pkt_par;
    logic              err;

    assign bus.s_ready    = !valid_q || bus.m_ready;
    assign bus.m_valid    = valid_q;
    assign bus.m_data     = data_q;
    assign bus.m_last     = last_q;
    assign bus.m_beat_par = beat_par_q;
    assign bus.m_pkt_par  = pkt_par_q;
    assign bus.m_err      = err_q;

    assign accept = bus.s_valid && bus.s_ready;
    assign x      = ^bus.s_data;

    // In IDLE the incoming beat opens a packet, so it uses the live mode/check inputs
    // and a clean accumulator; mid-packet beats use the values latched on beat one.
    always_comb begin
        state_nxt    = state;
        beat_cnt_nxt = beat_cnt;
        acc_nxt      = acc;
        mode_nxt     = mode_q;
        chk_nxt      = chk_q;

        first    = (state == IDLE);
        mode_cur = first ? bus.mode_odd : mode_q;
        chk_cur  = first ? bus.chk_en : chk_q;
        acc_cur  = first ? 1'b0 : acc;
        count    = first ? BW'(1) : beat_cnt + BW'(1);
        forced   = (count == BW'(MAX_BEATS)) && !bus.s_last;
        is_last  = bus.s_last || (count == BW'(MAX_BEATS));
        pkt_par  = acc_cur ^ x ^ mode_cur;
        err      = forced || (chk_cur && is_last && (bus.s_par != pkt_par));

        if (accept) begin
            mode_nxt = mode_cur;
            chk_nxt  = chk_cur;
            if (is_last) begin
                state_nxt    = IDLE;
                acc_nxt      = 1'b0;
                beat_cnt_nxt = '0;
            end else begin
                state_nxt    = ACTIVE;
                acc_nxt      = acc_cur ^ x;
                beat_cnt_nxt = count;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            beat_cnt <= '0;
            acc      <= 1'b0;
            mode_q   <= 1'b0;
            chk_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_cnt_nxt;
            acc      <= acc_nxt;
            mode_q   <= mode_nxt;
            chk_q    <= chk_nxt;
        end
    end

    // A new accept reloads the output stage even while it drains, keeping 1 beat/clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            data_q     <= '0;
            last_q     <= 1'b0;
            beat_par_q <= 1'b0;
            pkt_par_q  <= 1'b0;
            err_q      <= 1'b0;
        end else if (accept) begin
            valid_q    <= 1'b1;
            data_q     <= bus.s_data;
            last_q     <= is_last;
            beat_par_q <= x ^ mode_cur;
            pkt_par_q  <= is_last ? pkt_par : 1'b0;
            err_q      <= is_last ? err : 1'b0;
        end else if (bus.m_ready) begin
            valid_q    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (accept && is_last && err && (err_cnt != {CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule
